// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package fifo_pkg;
    localparam int FWFT_OFF  = 0;
    localparam int FWFT_ON   = 1;
    localparam int TH_MARGIN = 4;

    // Smallest r with 2**r >= n; usable in parameter and port declarations.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]         rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with wrap-bit pointers, status/threshold flags, sticky errors,
// flush, and a choice of registered or first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AFULL_TH  = DEPTH - TH_MARGIN,
    parameter int AEMPTY_TH = TH_MARGIN,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic                    clr_err,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   level,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
    localparam logic [AW:0] AF_L    = AFULL_TH[AW:0];
    localparam logic [AW:0] AE_L    = AEMPTY_TH[AW:0];

    if (DEPTH < 4 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two in 4..4096");
    end
    if (AEMPTY_TH >= AFULL_TH) begin : g_bad_th
        $error("sync_fifo_param: AEMPTY_TH must be below AFULL_TH");
    end
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be in 1..64");
    end

    logic [AW:0]        wr_ptr, rd_ptr;
    logic               wr_acc, rd_acc;
    logic [DATA_W-1:0]  ram_q;

    assign level        = wr_ptr - rd_ptr;
    assign empty        = (level == '0);
    assign full         = (level == DEPTH_L);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    // Flush blocks both ports so nothing is committed in the flush cycle.
    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A new error event takes precedence over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !flush)       overflow <= 1'b1;
            else if (clr_err)                  overflow <= 1'b0;
            if (rd_en && empty && !flush)      underflow <= 1'b1;
            else if (clr_err)                  underflow <= 1'b0;
        end
    end

    fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        // Gate the head word so an empty FIFO never exposes unwritten memory.
        assign rd_data  = empty ? '0 : ram_q;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_q;
        logic              rd_v;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
                rd_v <= 1'b0;
            end else begin
                rd_v <= rd_acc;
                if (rd_acc) rd_q <= ram_q;
            end
        end
        assign rd_data  = rd_q;
        assign rd_valid = rd_v;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: default FIFO, an 8-deep FIFO for wrap, and a FWFT FIFO.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] flush, wr_en, rd_en, clr_err;
    logic [7:0] wr_data [3];
    logic [7:0] rd0, rd1, rd2;
    logic [2:0] rd_valid, empty, full, afull, aempty, ovf, unf;
    logic [6:0] lvl0, lvl2;
    logic [3:0] lvl1;

    int checks = 0;
    int failures = 0;
    int mlev [3];
    bit mov [3];
    bit mun [3];
    logic [7:0] mlast [3];
    logic [7:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    sync_fifo_param u_def (
        .clk(clk), .rst(rst), .flush(flush[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .clr_err(clr_err[0]), .rd_data(rd0), .rd_valid(rd_valid[0]),
        .empty(empty[0]), .full(full[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
        .level(lvl0), .overflow(ovf[0]), .underflow(unf[0]));

    sync_fifo_param #(.DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) u_w8 (
        .clk(clk), .rst(rst), .flush(flush[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .clr_err(clr_err[1]), .rd_data(rd1), .rd_valid(rd_valid[1]),
        .empty(empty[1]), .full(full[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
        .level(lvl1), .overflow(ovf[1]), .underflow(unf[1]));

    sync_fifo_param #(.FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .flush(flush[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .clr_err(clr_err[2]), .rd_data(rd2), .rd_valid(rd_valid[2]),
        .empty(empty[2]), .full(full[2]), .almost_full(afull[2]), .almost_empty(aempty[2]),
        .level(lvl2), .overflow(ovf[2]), .underflow(unf[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] lvl(int i);
        case (i)
            0:       return lvl0;
            1:       return {3'b000, lvl1};
            default: return lvl2;
        endcase
    endfunction

    function automatic logic [7:0] rdd(int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic [7:0] qpop(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic qpush(int i, logic [7:0] d);
        case (i)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qclr(int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk_state(int i, bit ra);
        int dep, aft, aet;
        dep = (i == 1) ? 8 : 64;
        aft = (i == 1) ? 6 : 60;
        aet = (i == 1) ? 2 : 4;
        chk($sformatf("level%0d", i),        64'(lvl(i)),  64'(mlev[i]));
        chk($sformatf("empty%0d", i),        64'(empty[i]),  64'(mlev[i] == 0));
        chk($sformatf("full%0d", i),         64'(full[i]),   64'(mlev[i] == dep));
        chk($sformatf("almost_full%0d", i),  64'(afull[i]),  64'(mlev[i] >= aft));
        chk($sformatf("almost_empty%0d", i), 64'(aempty[i]), 64'(mlev[i] <= aet));
        chk($sformatf("overflow%0d", i),     64'(ovf[i]),    64'(mov[i]));
        chk($sformatf("underflow%0d", i),    64'(unf[i]),    64'(mun[i]));
        if (i == 2) begin
            chk("rd_valid2", 64'(rd_valid[2]), 64'(mlev[2] != 0));
            if (mlev[2] != 0) chk("fwft_data", 64'(rd2), 64'(q2[0]));
            else              chk("fwft_data", 64'(rd2), 64'h0);
        end else begin
            chk($sformatf("rd_valid%0d", i), 64'(rd_valid[i]), 64'(ra));
            chk($sformatf("rd_data%0d", i),  64'(rdd(i)),      64'(mlast[i]));
        end
    endtask

    // Drive one cycle on instance i, update the model, then check outputs after the edge.
    task automatic cyc(int i, bit w, bit r, logic [7:0] d, bit f = 1'b0, bit c = 1'b0);
        int dep;
        bit wa, ra;
        logic [7:0] hv;
        dep = (i == 1) ? 8 : 64;
        wa = w && !f && (mlev[i] != dep);
        ra = r && !f && (mlev[i] != 0);
        if (c) begin mov[i] = 1'b0; mun[i] = 1'b0; end
        if (w && !f && mlev[i] == dep) mov[i] = 1'b1;
        if (r && !f && mlev[i] == 0)   mun[i] = 1'b1;
        if (ra) begin
            hv = qpop(i);
            if (i == 2) chk("fwft_head", 64'(rd2), 64'(hv));
            else        mlast[i] = hv;
        end
        if (wa) qpush(i, d);
        mlev[i] = mlev[i] + int'(wa) - int'(ra);
        if (f) begin mlev[i] = 0; qclr(i); end
        wr_en[i] = w; rd_en[i] = r; wr_data[i] = d; flush[i] = f; clr_err[i] = c;
        @(posedge clk); #1;
        wr_en[i] = 1'b0; rd_en[i] = 1'b0; flush[i] = 1'b0; clr_err[i] = 1'b0;
        chk_state(i, ra);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            mlev[i] = 0; mov[i] = 1'b0; mun[i] = 1'b0; mlast[i] = 8'h00; qclr(i);
        end
        for (int i = 0; i < 3; i++) chk_state(i, 1'b0);
        wr_en = '0; rd_en = '0; flush = '0; clr_err = '0;
        rst = 1'b0;
    endtask

    initial begin
        wr_en = '0; rd_en = '0; flush = '0; clr_err = '0;
        for (int i = 0; i < 3; i++) wr_data[i] = 8'h00;
        do_reset();

        // Fill and drain the default FIFO, crossing both thresholds.
        for (int k = 0; k < 64; k++) cyc(0, 1'b1, 1'b0, 8'(k));
        for (int k = 0; k < 64; k++) cyc(0, 1'b0, 1'b1, 8'h00);

        // Empty with write+read: write wins, underflow sets.
        cyc(0, 1'b1, 1'b1, 8'h5A);
        for (int k = 0; k < 63; k++) cyc(0, 1'b1, 1'b0, 8'(k + 8'h40));
        // Full with write+read: read wins, overflow sets.
        cyc(0, 1'b1, 1'b1, 8'hEE);
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Down to 10 entries, then flush with a concurrent write.
        for (int k = 0; k < 53; k++) cyc(0, 1'b0, 1'b1, 8'h00);
        cyc(0, 1'b1, 1'b0, 8'hCC, 1'b1);
        cyc(0, 1'b1, 1'b0, 8'h11);
        cyc(0, 1'b0, 1'b1, 8'h00);

        // Pointer wrap on the 8-deep FIFO.
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1'b1, 1'b0, 8'(k));
            cyc(1, 1'b0, 1'b1, 8'h00);
        end
        // Underflow event beats a same-cycle clear.
        cyc(1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // First-word-fall-through.
        cyc(2, 1'b1, 1'b0, 8'hA5);
        cyc(2, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 3; k++) cyc(2, 1'b1, 1'b0, 8'(k + 8'h30));
        cyc(2, 1'b1, 1'b1, 8'h40);
        for (int k = 0; k < 4; k++) cyc(2, 1'b0, 1'b1, 8'h00);

        // Reset in the middle of a write burst.
        for (int k = 0; k < 5; k++) cyc(0, 1'b1, 1'b0, 8'(k + 8'h20));
        wr_en[0] = 1'b1; wr_data[0] = 8'h99;
        do_reset();
        cyc(0, 1'b1, 1'b0, 8'h77);
        cyc(0, 1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 64, number of entries (power of two, 4..4096).
REQ-003 SHALL provide parameter AFULL_TH, default DEPTH-4, level at or above which almost_full asserts.
REQ-004 SHALL provide parameter AEMPTY_TH, default 4, level at or below which almost_empty asserts.
REQ-005 SHALL provide parameter FWFT, default 0, read mode: 0 = registered standard read, 1 = first-word-fall-through.
REQ-006 SHALL provide clk  input  1  rising-edge clock for all state.
REQ-007 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL provide flush  input  1  synchronous empty request.
REQ-009 SHALL provide wr_en  input  1  write request.
REQ-010 SHALL provide wr_data  input  DATA_W  write data.
REQ-011 SHALL provide rd_en  input  1  read request (pop in FWFT mode).
REQ-012 SHALL provide clr_err  input  1  synchronous clear of sticky error flags.
REQ-013 SHALL provide rd_data  output  DATA_W  read data.
REQ-014 SHALL provide rd_valid  output  1  rd_data qualifier.
REQ-015 SHALL provide empty, full, almost_full, almost_empty  output  1 each  status flags.
REQ-016 SHALL provide level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 SHALL provide overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Write SHALL be accepted iff wr_en && !full && !flush; accepted data is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-019 Read SHALL be accepted iff rd_en && !empty && !flush; rd_ptr increments modulo DEPTH.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits wide including a wrap bit; level SHALL equal wr_ptr-rd_ptr modulo 2^(log2(DEPTH)+1).
REQ-021 empty SHALL equal (level==0), full SHALL equal (level==DEPTH), almost_full SHALL equal (level>=AFULL_TH), and almost_empty SHALL equal (level<=AEMPTY_TH), all derived from registered state.
REQ-022 Simultaneous accepted read and write SHALL leave level unchanged.
REQ-023 When full, rd_en and wr_en SHALL cause the read to be accepted and the write to be rejected; level SHALL become DEPTH-1.
REQ-024 When empty, rd_en and wr_en SHALL cause the write to be accepted and the read to be rejected; level SHALL become 1.
REQ-025 In FWFT=0, rd_data SHALL present the popped word one cycle after an accepted read, rd_valid SHALL pulse high for exactly that cycle, and rd_data SHALL otherwise hold its last value.
REQ-026 In FWFT=1, rd_data SHALL present the head entry combinationally, rd_valid SHALL equal !empty, and an accepted read SHALL advance to the next entry in the following cycle.
REQ-027 overflow SHALL set on any cycle with wr_en && full && !flush; underflow SHALL set on rd_en && empty && !flush; both SHALL hold until clr_err or rst, and a set event SHALL win over clr_err in the same cycle.
REQ-028 flush SHALL have priority over wr_en/rd_en: the next cycle SHALL have both pointers at 0, level at 0, and rd_valid at 0; memory contents SHALL be left unchanged and error flags unaffected.
REQ-029 Memory SHALL not be reset; a read of a never-written location SHALL never be accepted.

Reset
REQ-030 rst SHALL asynchronously force wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, giving empty=1, full=0, almost_empty=1, almost_full=0.
REQ-031 rst asserted mid-burst SHALL discard all stored entries; the first post-reset write SHALL be the first word read.

Structure
REQ-032 Package fifo_pkg SHALL hold the pointer-width function clog2, the mode constants FWFT_OFF/FWFT_ON, and the default threshold margin (4).
REQ-033 Storage SHALL be a sub-module fifo_ram (DATA_W x DEPTH, one write port, one asynchronous read port, no reset); control logic SHALL reside in sync_fifo_param.
REQ-034 Elaboration SHALL fail if DEPTH is not a power of two or if AEMPTY_TH >= AFULL_TH.

Verification
REQ-035 Fill/drain (defaults): write 0x00..0x3F in 64 cycles -> full=1 and level=64 after the last write; read 64 -> data 0x00..0x3F in order, empty=1.
REQ-036 Wrap: DEPTH=8, do 20 write/read pairs with data=i -> level stays at 0 or 1, data in order, no error flags set.
REQ-037 Boundaries: full plus wr_en+rd_en -> level=63 and overflow=1; empty plus wr_en+rd_en -> level=1 and underflow=1; clr_err -> both flags 0.
REQ-038 Thresholds: level 59->60 sets almost_full, and 5->4 sets almost_empty, each in the cycle level changes.
REQ-039 FWFT=1: write 0xA5 -> rd_data=0xA5 and rd_valid=1 the next cycle without rd_en; pop -> empty=1.
REQ-040 Flush and reset: with 10 entries, pulse flush plus wr_en -> level=0 and the write is dropped; assert rst mid-write-burst -> all outputs match REQ-030 immediately.
